// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: host load port, redirect inputs from decode/execute,
// and the IR/PC/squash outputs presented to decode.
interface instruction_fetch_if #(
  parameter int IMEM_DEPTH = 256
) ();
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          en;
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          jump;
  logic [27:0]   address;
  logic          beq;
  logic          bne;
  logic          bgt;
  logic [31:0]   offset;
  logic [31:0]   br_pc;
  logic          cmp_zero;
  logic          cmp_neg;
  logic [31:0]   IR;
  logic [31:0]   PC;
  logic          jnoWB;
  logic          bnoWB;
  logic          halted;

  modport master (
    output en, load_we, load_addr, load_data,
    output jump, address, beq, bne, bgt, offset, br_pc, cmp_zero, cmp_neg,
    input  IR, PC, jnoWB, bnoWB, halted
  );

  modport slave (
    input  en, load_we, load_addr, load_data,
    input  jump, address, beq, bne, bgt, offset, br_pc, cmp_zero, cmp_neg,
    output IR, PC, jnoWB, bnoWB, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, instruction memory with host load port,
// branch/jump redirect and wrong-path squash flags, halt detection.
module instruction_fetch #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic rst,
  instruction_fetch_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [31:0]   r_imem [IMEM_DEPTH];
  logic [31:0]   r_pc_reg;
  logic [31:0]   r_ir;
  logic [31:0]   r_pc;

  logic          w_in_run;
  logic          w_take_br;
  logic          w_jno;
  logic          w_bno;
  logic          w_halt_hit;
  logic          w_fetch;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_br_target;
  logic [31:0]   w_j_target;
  logic [31:0]   w_pc_next;
  logic [AW-1:0] w_index;

  assign w_in_run    = bus.en && (r_state == ST_RUN);
  // bgt uses the raw sign bit of A-B; overflow is deliberately not corrected
  assign w_take_br   = (bus.beq & bus.cmp_zero)
                     | (bus.bne & ~bus.cmp_zero)
                     | (bus.bgt & ~bus.cmp_zero & ~bus.cmp_neg);
  assign w_bno       = w_in_run & w_take_br;
  assign w_jno       = w_in_run & bus.jump & ~w_take_br;
  assign w_halt_hit  = w_in_run && (r_ir == HALT_WORD) && !w_jno && !w_bno;

  assign w_pc_plus4  = r_pc_reg + 32'd4;
  assign w_br_target = bus.br_pc + bus.offset;
  assign w_j_target  = {bus.br_pc[31:28], bus.address};
  assign w_index     = r_pc_reg[AW+1:2];

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    if (!bus.en) begin
      w_state_next = ST_LOAD;
    end else begin
      case (r_state)
        ST_LOAD: begin
          w_state_next = ST_RUN;
          w_fetch      = 1'b1;
        end
        ST_RUN: begin
          if (w_halt_hit) begin
            w_state_next = ST_HALT;
          end else begin
            w_fetch = 1'b1;
          end
        end
        ST_HALT: w_state_next = ST_HALT;
        default: w_state_next = ST_LOAD;
      endcase
    end
  end

  // Redirects only apply in RUN; the first edge out of LOAD fetches sequentially
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_in_run && w_take_br) begin
      w_pc_next = w_br_target;
    end else if (w_in_run && bus.jump) begin
      w_pc_next = w_j_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_LOAD;
      r_pc_reg <= RESET_PC;
      r_ir     <= 32'h0;
      r_pc     <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (w_fetch) begin
        r_ir     <= r_imem[w_index];
        r_pc     <= w_pc_plus4;
        r_pc_reg <= w_pc_next;
      end else if (w_halt_hit) begin
        r_ir <= 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.en && bus.load_we) begin
      r_imem[bus.load_addr] <= bus.load_data;
    end
  end

  assign bus.IR     = r_ir;
  assign bus.PC     = r_pc;
  assign bus.jnoWB  = w_jno;
  assign bus.bnoWB  = w_bno;
  assign bus.halted = (r_state == ST_HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed, table-driven bench for instruction_fetch plus hand-written
// sequences for load-port gating and asynchronous reset.
module tb_instruction_fetch;
  localparam int DEPTH = 256;
  localparam int NV    = 25;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  instruction_fetch_if #(.IMEM_DEPTH(DEPTH)) fif ();

  instruction_fetch #(
    .IMEM_DEPTH(DEPTH),
    .RESET_PC  (32'h0),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic        jump;
    logic [27:0] address;
    logic        beq;
    logic        bne;
    logic        bgt;
    logic [31:0] offset;
    logic [31:0] br_pc;
    logic        cz;
    logic        cn;
    logic        ejno;
    logic        ebno;
    logic [31:0] eir;
    logic [31:0] epc;
    logic        ehalt;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic en, input logic jump, input logic [27:0] address,
                              input logic beq, input logic bne, input logic bgt,
                              input logic [31:0] offset, input logic [31:0] br_pc,
                              input logic cz, input logic cn, input logic ejno, input logic ebno,
                              input logic [31:0] eir, input logic [31:0] epc, input logic ehalt);
    vec_t v;
    v.en = en; v.jump = jump; v.address = address;
    v.beq = beq; v.bne = bne; v.bgt = bgt;
    v.offset = offset; v.br_pc = br_pc; v.cz = cz; v.cn = cn;
    v.ejno = ejno; v.ebno = ebno; v.eir = eir; v.epc = epc; v.ehalt = ehalt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fif.en       = v.en;
    fif.jump     = v.jump;
    fif.address  = v.address;
    fif.beq      = v.beq;
    fif.bne      = v.bne;
    fif.bgt      = v.bgt;
    fif.offset   = v.offset;
    fif.br_pc    = v.br_pc;
    fif.cmp_zero = v.cz;
    fif.cmp_neg  = v.cn;
  endtask

  task automatic clear_redirect();
    fif.jump = 1'b0; fif.address = '0; fif.beq = 1'b0; fif.bne = 1'b0; fif.bgt = 1'b0;
    fif.offset = '0; fif.br_pc = '0; fif.cmp_zero = 1'b0; fif.cmp_neg = 1'b0;
  endtask

  function automatic logic [31:0] prog_word(input int i);
    logic [31:0] w;
    case (i)
      0:       w = 32'h2008_0005;
      1:       w = 32'h2009_0003;
      2:       w = 32'h0109_5020;
      3:       w = 32'hFFFF_FFFF;
      default: w = 32'hA000_0000 | 32'(i);
    endcase
    return w;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    fif.en = 1'b0; fif.load_we = 1'b0; fif.load_addr = '0; fif.load_data = '0;
    clear_redirect();

    // args: en jump address beq bne bgt offset br_pc cz cn | jno bno IR PC halted
    vecs[0]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h2008_0005,32'h4,0);
    vecs[1]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h2009_0003,32'h8,0);
    vecs[2]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h0109_5020,32'hC,0);
    vecs[3]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hFFFF_FFFF,32'h10,0);
    vecs[4]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h0,32'h10,1);
    vecs[5]  = mk(1,1,28'h40,0,0,0,32'h0,32'h8,0,0, 0,0,32'h0,32'h10,1);
    vecs[6]  = mk(0,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h0,32'h10,0);
    vecs[7]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hA000_0004,32'h14,0);
    vecs[8]  = mk(1,1,28'h40,0,0,0,32'h0,32'h8,0,0, 1,0,32'hA000_0005,32'h18,0);
    vecs[9]  = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hA000_0010,32'h44,0);
    vecs[10] = mk(1,0,28'h0,1,0,0,32'hFFFF_FFF8,32'hC,1,0, 0,1,32'hA000_0011,32'h48,0);
    vecs[11] = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'h2009_0003,32'h8,0);
    vecs[12] = mk(1,0,28'h0,1,0,0,32'hFFFF_FFF8,32'hC,0,0, 0,0,32'h0109_5020,32'hC,0);
    vecs[13] = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hFFFF_FFFF,32'h10,0);
    vecs[14] = mk(1,0,28'h0,0,1,0,32'h20,32'h40,0,0, 0,1,32'hA000_0004,32'h14,0);
    vecs[15] = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hA000_0018,32'h64,0);
    vecs[16] = mk(1,0,28'h0,0,0,1,32'h8,32'h10,0,0, 0,1,32'hA000_0019,32'h68,0);
    vecs[17] = mk(1,0,28'h0,0,0,1,32'h8,32'h10,0,1, 0,0,32'hA000_0006,32'h1C,0);
    vecs[18] = mk(1,0,28'h0,0,0,1,32'h8,32'h10,1,0, 0,0,32'hA000_0007,32'h20,0);
    vecs[19] = mk(1,0,28'h0,0,1,0,32'h8,32'h10,1,0, 0,0,32'hA000_0008,32'h24,0);
    vecs[20] = mk(1,1,28'h40,1,0,0,32'h4,32'h10,1,0, 0,1,32'hA000_0009,32'h28,0);
    vecs[21] = mk(1,1,28'h70,0,0,0,32'h0,32'h3000_0000,0,0, 1,0,32'hA000_0005,32'h18,0);
    vecs[22] = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hA000_001C,32'h3000_0074,0);
    vecs[23] = mk(0,1,28'h40,0,0,0,32'h0,32'h8,0,0, 0,0,32'hA000_001C,32'h3000_0074,0);
    vecs[24] = mk(1,0,28'h0,0,0,0,32'h0,32'h0,0,0, 0,0,32'hA000_001D,32'h3000_0078,0);

    // Reset state
    #3;
    chk("reset_IR", 0, fif.IR, 32'h0);
    chk("reset_PC", 0, fif.PC, 32'h0);
    chk("reset_halted", 0, {31'b0, fif.halted}, 32'h0);
    chk("reset_jnoWB", 0, {31'b0, fif.jnoWB}, 32'h0);
    chk("reset_bnoWB", 0, {31'b0, fif.bnoWB}, 32'h0);
    tick();
    rst = 1'b1;

    // Host load of the program while en=0
    for (int i = 0; i < 32; i++) begin
      fif.load_we   = 1'b1;
      fif.load_addr = 8'(i);
      fif.load_data = prog_word(i);
      tick();
    end
    fif.load_we = 1'b0;
    $display("loaded 32 words");

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k]);
      #1;
      chk("jnoWB", k, {31'b0, fif.jnoWB}, {31'b0, vecs[k].ejno});
      chk("bnoWB", k, {31'b0, fif.bnoWB}, {31'b0, vecs[k].ebno});
      tick();
      chk("IR", k, fif.IR, vecs[k].eir);
      chk("PC", k, fif.PC, vecs[k].epc);
      chk("halted", k, {31'b0, fif.halted}, {31'b0, vecs[k].ehalt});
      $display("vec %0d en=%0b IR=%h PC=%h jno=%0b bno=%0b halted=%0b",
               k, vecs[k].en, fif.IR, fif.PC, fif.jnoWB, fif.bnoWB, fif.halted);
    end

    // Load port must be ignored while running; re-read the word afterwards
    clear_redirect();
    fif.en = 1'b1;
    fif.load_we = 1'b1; fif.load_addr = 8'd30; fif.load_data = 32'hDEAD_BEEF;
    tick();
    chk("ld_ign_IR0", 0, fif.IR, 32'hA000_001E);
    chk("ld_ign_PC0", 0, fif.PC, 32'h3000_007C);
    $display("load-gate step 0 IR=%h PC=%h", fif.IR, fif.PC);
    fif.beq = 1'b1; fif.cmp_zero = 1'b1; fif.br_pc = 32'h78; fif.offset = 32'h0;
    #1;
    chk("ld_ign_bno", 1, {31'b0, fif.bnoWB}, 32'h1);
    tick();
    chk("ld_ign_IR1", 1, fif.IR, 32'hA000_001F);
    $display("load-gate step 1 IR=%h PC=%h", fif.IR, fif.PC);
    clear_redirect();
    tick();
    chk("ld_ign_IR2", 2, fif.IR, 32'hA000_001E);
    chk("ld_ign_PC2", 2, fif.PC, 32'h7C);
    $display("load-gate step 2 IR=%h PC=%h", fif.IR, fif.PC);
    fif.load_we = 1'b0;

    // Asynchronous reset between edges with a pending jump
    fif.jump = 1'b1; fif.address = 28'h40; fif.br_pc = 32'h0;
    #2;
    rst = 1'b0;
    #1;
    chk("areset_IR", 0, fif.IR, 32'h0);
    chk("areset_PC", 0, fif.PC, 32'h0);
    chk("areset_halted", 0, {31'b0, fif.halted}, 32'h0);
    chk("areset_jnoWB", 0, {31'b0, fif.jnoWB}, 32'h0);
    $display("async reset IR=%h PC=%h", fif.IR, fif.PC);
    tick();
    chk("areset_hold_IR", 1, fif.IR, 32'h0);
    rst = 1'b1;
    clear_redirect();
    tick();
    chk("post_reset_IR0", 0, fif.IR, 32'h2008_0005);
    chk("post_reset_PC0", 0, fif.PC, 32'h4);
    $display("post-reset step 0 IR=%h PC=%h", fif.IR, fif.PC);
    tick();
    chk("post_reset_IR1", 1, fif.IR, 32'h2009_0003);
    chk("post_reset_PC1", 1, fif.PC, 32'h8);
    $display("post-reset step 1 IR=%h PC=%h", fif.IR, fif.PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
